// File: rtl/soc_led_pwm.sv
// Three-channel LED PWM dimmer with an Avalon-MM register slave (DUTY0..2, CTRL).
// Define SOC_LED_PWM_BLINK_EN to add the CTRL.BLINK slow on/off gating.
module soc_led_pwm #(
  parameter int PWM_BITS = 8,
  parameter int PRESCALE = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic [2:0]  led_in,
  output logic [2:0]  led_pwm
);

`ifdef SOC_LED_PWM_BLINK_EN
  localparam int CTRL_W = 3;
`else
  localparam int CTRL_W = 2;
`endif

  localparam logic [15:0]         PRE_LAST = 16'(PRESCALE - 1);
  localparam logic [PWM_BITS-1:0] CNT_MAX  = '1;

  logic [15:0]         pre_q, pre_d;
  logic [PWM_BITS-1:0] cnt_q, cnt_d;
  logic [PWM_BITS-1:0] duty_q [3];
  logic [PWM_BITS-1:0] duty_d [3];
  logic [PWM_BITS-1:0] shadow_q [3];
  logic [PWM_BITS-1:0] shadow_d [3];
  logic [CTRL_W-1:0]   ctrl_q, ctrl_d;
  logic [2:0]          led_q, led_d;
  logic                we, tick, period_end, blink_gate;
  logic [2:0]          raw;
  logic                unused_wd;

  assign unused_wd = ^writedata;

`ifdef SOC_LED_PWM_BLINK_EN
  logic [3:0] blink_q, blink_d;
  assign blink_d    = period_end ? blink_q + 4'd1 : blink_q;
  assign blink_gate = ~ctrl_q[2] | blink_q[3];

  always_ff @(posedge clk) begin
    if (reset) blink_q <= '0;
    else       blink_q <= blink_d;
  end
`else
  assign blink_gate = 1'b1;
`endif

  always_comb begin
    we         = chipselect & ~write_n;
    tick       = (pre_q == PRE_LAST);
    period_end = tick && (cnt_q == CNT_MAX);
    pre_d      = tick ? '0 : pre_q + 16'd1;
    cnt_d      = tick ? cnt_q + 1'b1 : cnt_q;

    duty_d = duty_q;
    ctrl_d = ctrl_q;
    if (we) begin
      case (address)
        2'd0:    duty_d[0] = writedata[PWM_BITS-1:0];
        2'd1:    duty_d[1] = writedata[PWM_BITS-1:0];
        2'd2:    duty_d[2] = writedata[PWM_BITS-1:0];
        default: ctrl_d    = writedata[CTRL_W-1:0];
      endcase
    end

    // Shadows take the post-write DUTY value so a write landing on period end is not lost.
    shadow_d = period_end ? duty_d : shadow_q;

    for (int i = 0; i < 3; i++) begin
      raw[i] = led_in[i] & ctrl_q[0] & (cnt_q < shadow_q[i]) & blink_gate;
    end
    led_d = raw ^ {3{ctrl_q[1]}};

    case (address)
      2'd0:    readdata = 32'(duty_q[0]);
      2'd1:    readdata = 32'(duty_q[1]);
      2'd2:    readdata = 32'(duty_q[2]);
      default: readdata = 32'(ctrl_q);
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pre_q    <= '0;
      cnt_q    <= '0;
      duty_q   <= '{default: '0};
      shadow_q <= '{default: '0};
      ctrl_q   <= '0;
      led_q    <= '0;
    end else begin
      pre_q    <= pre_d;
      cnt_q    <= cnt_d;
      duty_q   <= duty_d;
      shadow_q <= shadow_d;
      ctrl_q   <= ctrl_d;
      led_q    <= led_d;
    end
  end

  assign led_pwm = led_q;

endmodule

// File: tb/tb_soc_led_pwm.sv
// Directed bench for soc_led_pwm at PWM_BITS=4, PRESCALE=2 (32-clk PWM period).
module tb_soc_led_pwm;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic [2:0]  led_in = '0;
  logic [2:0]  led_pwm;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  soc_led_pwm #(.PWM_BITS(4), .PRESCALE(2)) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .led_in(led_in), .led_pwm(led_pwm)
  );

  always #5 clk = ~clk;

  // cyc == n during the n-th cycle after the reset edge
  always @(posedge clk) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; chipselect = 1'b0; write_n = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic test_reset();
    led_in = 3'b000;
    do_reset();
    for (int a = 0; a < 4; a++) begin
      address = 2'(a); #1;
      tests++;
      if (readdata !== 32'd0) begin
        fails++; $display("FAIL reset_read addr=%0d got=%h exp=0", a, readdata);
      end
    end
    tests++;
    if (led_pwm !== 3'b000) begin
      fails++; $display("FAIL reset_led got=%b exp=000", led_pwm);
    end
  endtask

  task automatic test_basic();
    logic [2:0] exp;
    int m;
    do_reset();
    led_in = 3'b001;
    bus_write(2'd0, 32'd4);
    bus_write(2'd3, 32'd1);
    for (int n = 2; n < 100; n++) begin
      wait_cyc(n);
      m = n - 1;
      exp = {2'b00, (m >= 32) && ((m / 2) % 16 < 4)};
      tests++;
      if (led_pwm !== exp) begin
        fails++; $display("FAIL basic_duty4 cyc=%0d got=%b exp=%b", n, led_pwm, exp);
      end
    end
  endtask

  task automatic test_duty_update();
    logic [2:0] exp;
    int m;
    do_reset();
    led_in = 3'b010;
    bus_write(2'd1, 32'd0);
    bus_write(2'd3, 32'd1);
    wait_cyc(10);
    bus_write(2'd1, 32'hFFFF_FFFF);
    address = 2'd1; #1;
    tests++;
    if (readdata !== 32'd15) begin
      fails++; $display("FAIL duty1_readback got=%h exp=0000000f", readdata);
    end
    for (int n = 12; n < 100; n++) begin
      wait_cyc(n);
      m = n - 1;
      exp = {1'b0, (m >= 32) && ((m / 2) % 16 < 15), 1'b0};
      tests++;
      if (led_pwm !== exp) begin
        fails++; $display("FAIL midperiod_update cyc=%0d got=%b exp=%b", n, led_pwm, exp);
      end
    end
  endtask

  task automatic test_coincident();
    logic [2:0] exp;
    int m;
    do_reset();
    led_in = 3'b001;
    bus_write(2'd0, 32'd2);
    bus_write(2'd3, 32'd1);
    wait_cyc(31);
    bus_write(2'd0, 32'd6);
    for (int n = 32; n < 72; n++) begin
      wait_cyc(n);
      m = n - 1;
      exp = {2'b00, (m >= 32) && ((m / 2) % 16 < 6)};
      tests++;
      if (led_pwm !== exp) begin
        fails++; $display("FAIL coincident_write cyc=%0d got=%b exp=%b", n, led_pwm, exp);
      end
    end
  endtask

  task automatic test_inv();
    do_reset();
    led_in = 3'b000;
    bus_write(2'd3, 32'd3);
    wait_cyc(2);
    tests++;
    if (led_pwm !== 3'b111) begin
      fails++; $display("FAIL inv_en got=%b exp=111", led_pwm);
    end
    bus_write(2'd3, 32'd2);
    address = 2'd3; #1;
    tests++;
    if (readdata !== 32'd2) begin
      fails++; $display("FAIL ctrl_readback got=%h exp=00000002", readdata);
    end
    wait_cyc(4);
    led_in = 3'b111;
    bus_write(2'd0, 32'd15);
    bus_write(2'd1, 32'd15);
    bus_write(2'd2, 32'd15);
    for (int n = 8; n < 71; n++) begin
      wait_cyc(n);
      tests++;
      if (led_pwm !== 3'b111) begin
        fails++; $display("FAIL inv_disabled cyc=%0d got=%b exp=111", n, led_pwm);
      end
    end
    bus_write(2'd3, 32'd0);
    for (int n = 72; n < 80; n++) begin
      wait_cyc(n);
      tests++;
      if (led_pwm !== 3'b000) begin
        fails++; $display("FAIL disabled_noinv cyc=%0d got=%b exp=000", n, led_pwm);
      end
    end
  endtask

  task automatic test_led_in();
    do_reset();
    led_in = 3'b000;
    bus_write(2'd0, 32'd15);
    bus_write(2'd1, 32'd15);
    bus_write(2'd2, 32'd15);
    bus_write(2'd3, 32'd1);
    wait_cyc(40);
    tests++;
    if (led_pwm !== 3'b000) begin
      fails++; $display("FAIL ledin_idle got=%b exp=000", led_pwm);
    end
    led_in = 3'b101;
    wait_cyc(41);
    tests++;
    if (led_pwm !== 3'b101) begin
      fails++; $display("FAIL ledin_latency_on got=%b exp=101", led_pwm);
    end
    led_in = 3'b010;
    wait_cyc(42);
    tests++;
    if (led_pwm !== 3'b010) begin
      fails++; $display("FAIL ledin_latency_swap got=%b exp=010", led_pwm);
    end
  endtask

  task automatic test_reset_mid();
    logic [2:0] exp;
    int m;
    do_reset();
    bus_write(2'd2, 32'd8);
    bus_write(2'd3, 32'd1);
    led_in = 3'b100;
    wait_cyc(45);
    tests++;
    if (led_pwm !== 3'b100) begin
      fails++; $display("FAIL pre_reset_on got=%b exp=100", led_pwm);
    end
    reset = 1'b1;
    address = 2'd0; writedata = 32'd7; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    reset = 1'b0; chipselect = 1'b0; write_n = 1'b1;
    tests++;
    if (led_pwm !== 3'b000) begin
      fails++; $display("FAIL midreset_led got=%b exp=000", led_pwm);
    end
    for (int a = 0; a < 4; a++) begin
      address = 2'(a); #1;
      tests++;
      if (readdata !== 32'd0) begin
        fails++; $display("FAIL midreset_read addr=%0d got=%h exp=0", a, readdata);
      end
    end
    bus_write(2'd2, 32'd8);
    bus_write(2'd3, 32'd1);
    for (int n = 2; n < 72; n++) begin
      wait_cyc(n);
      m = n - 1;
      exp = {(m >= 32) && ((m / 2) % 16 < 8), 2'b00};
      tests++;
      if (led_pwm !== exp) begin
        fails++; $display("FAIL restart_after_reset cyc=%0d got=%b exp=%b", n, led_pwm, exp);
      end
    end
  endtask

  task automatic test_blink();
    logic [2:0] exp;
    int m;
    do_reset();
    led_in = 3'b001;
    bus_write(2'd0, 32'd15);
    bus_write(2'd3, 32'd5);
    address = 2'd3; #1;
`ifdef SOC_LED_PWM_BLINK_EN
    tests++;
    if (readdata !== 32'd5) begin
      fails++; $display("FAIL blink_ctrl_read got=%h exp=00000005", readdata);
    end
    for (int n = 2; n < 560; n++) begin
      wait_cyc(n);
      m = n - 1;
      exp = {2'b00, (m >= 256) && (m < 512) && ((m / 2) % 16 < 15)};
      tests++;
      if (led_pwm !== exp) begin
        fails++; $display("FAIL blink_gate cyc=%0d got=%b exp=%b", n, led_pwm, exp);
      end
    end
`else
    tests++;
    if (readdata !== 32'd1) begin
      fails++; $display("FAIL ctrl_bit2_absent got=%h exp=00000001", readdata);
    end
    for (int n = 2; n < 72; n++) begin
      wait_cyc(n);
      m = n - 1;
      exp = {2'b00, (m >= 32) && ((m / 2) % 16 < 15)};
      tests++;
      if (led_pwm !== exp) begin
        fails++; $display("FAIL no_blink cyc=%0d got=%b exp=%b", n, led_pwm, exp);
      end
    end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_duty_update();
    test_coincident();
    test_inv();
    test_led_in();
    test_reset_mid();
    test_blink();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
